gouraud_step: RTL and testbench
===============================

# gouraud_step

Pixel-step sequencer feeding the blitter's four-lane 16-bit add array. Holds per-lane integer/fraction accumulators and increments, drives the array's A/B operands, mode and carry-latch strobe over a fraction phase then an integer phase, writes results back, and presents each stepped integer value to the pixel data path with a valid/ready handshake. It sits directly upstream of, and closes the loop around, the add array (Gouraud intensity / Z interpolation).

## Interface
Parameters:
- CNT_W, 16, width of the pixel step counter.

Ports:
- sys_clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- ld_we  in  1  register write strobe.
- ld_sel  in  3  0 acc_frac, 1 acc_int, 2 inc_frac, 3 inc_int, 4 imode (ld_data[2:0]); 5-7 ignored.
- ld_lane  in  2  lane 0-3 (ignored for imode).
- ld_data  in  16  write data, bit 0 LSB.
- start  in  1  begin run of `count` steps.
- count  in  CNT_W  number of pixel steps.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when a run completes.
- adda_0..adda_3  out  16  operand A per lane.
- addb_0..addb_3  out  16  operand B per lane.
- daddmode  out  3  add-array mode.
- carry_clk  out  1  carry-latch enable for the add array.
- addq_0..addq_3  in  16  add-array results (combinational in same cycle).
- pix_0..pix_3  out  16  integer accumulators.
- pix_valid  out  1  stepped pixel available.
- pix_ready  in  1  downstream accepts pixel.

## Operation
- Reset: state IDLE; all accumulators, increments, imode, counter zero; busy, done, pix_valid, carry_clk 0; daddmode 000; adda/addb 0.
- Loads accepted only in IDLE; ld_we while busy is dropped with no effect.
- States: IDLE, FRAC, INT, OUT.
- IDLE: start with count≠0 → load counter, go FRAC. start with count=0 → done pulse next cycle, stay IDLE. start while busy ignored.
- FRAC: adda=acc_frac, addb=inc_frac, daddmode=100 (carry-in suppressed), carry_clk=1 so carry-out is latched; acc_frac ← addq at edge; → INT.
- INT: adda=acc_int, addb=inc_int, daddmode=imode, carry_clk=0; acc_int ← addq; → OUT. Carry from FRAC is applied only for imode 001/010/011 (array's cinsel rule); saturation/eight-bit behaviour is the array's.
- OUT: pix_valid=1, pix_n=acc_int. On pix_ready: counter−1; if counter was 1 → IDLE with done pulse, else → FRAC. No pix_ready: hold, outputs stable.
- Outside FRAC/INT: adda/addb/daddmode driven 0, carry_clk 0.
- Counter wraps never: run ends at 1→0.

## Timing
- start sampled cycle 0; FRAC cycle 1; INT cycle 2; pix_valid first high cycle 3.
- pix_ready in cycle 3 → FRAC cycle 4; steady throughput 3 cycles/pixel.
- done high the cycle after the final handshake; busy low that same cycle; start accepted that cycle.
- reset asserted mid-run: next cycle IDLE, all registers zero, no done pulse, pix_valid low.

## Configuration
- GOURAUD_FRAC_EN defined: fraction accumulators/increments present; FRAC state used as above.
- Undefined: no fraction registers; ld_sel 0/2 writes ignored; FRAC skipped (IDLE/OUT → INT directly); carry_clk tied 0; throughput 2 cycles/pixel, first pix_valid cycle 2.

## Test plan
- Lane 0 acc_int=0x0010, acc_frac=0xC000, inc_int=0x0001, inc_frac=0x8000, imode=001, count=2, pix_ready=1 → pix_0=0x0012 cycle 3, 0x0013 cycle 6, done cycle 7, acc_frac=0xC000.
- Same setup, pix_ready low for 4 cycles at first pixel → pix_valid and pix_0=0x0012 held, array inputs 0, second pixel delayed exactly 4 cycles.
- imode=000, acc_frac carry generated → int result ignores carry (0x0011 first step).
- start with count=0 → done next cycle, busy never high, no pix_valid.
- reset asserted in INT of step 1 → next cycle IDLE, pix_0..3=0, done 0; ld_we during run has no effect.
- GOURAUD_FRAC_EN undefined, acc_int=0x0100, inc_int=0x0002, imode=000, count=3 → 0x0102/0x0104/0x0106 at 2-cycle spacing, carry_clk never high.

Source files
------------

// File: rtl/gouraud_step.sv
// Gouraud/Z pixel-step sequencer driving a four-lane 16-bit add array.
// Define GOURAUD_FRAC_EN to include the fraction accumulators and FRAC phase.
module gouraud_step #(
  parameter int CNT_W = 16
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             ld_we,
  input  logic [2:0]       ld_sel,
  input  logic [1:0]       ld_lane,
  input  logic [15:0]      ld_data,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [15:0]      adda_0,
  output logic [15:0]      adda_1,
  output logic [15:0]      adda_2,
  output logic [15:0]      adda_3,
  output logic [15:0]      addb_0,
  output logic [15:0]      addb_1,
  output logic [15:0]      addb_2,
  output logic [15:0]      addb_3,
  output logic [2:0]       daddmode,
  output logic             carry_clk,
  input  logic [15:0]      addq_0,
  input  logic [15:0]      addq_1,
  input  logic [15:0]      addq_2,
  input  logic [15:0]      addq_3,
  output logic [15:0]      pix_0,
  output logic [15:0]      pix_1,
  output logic [15:0]      pix_2,
  output logic [15:0]      pix_3,
  output logic             pix_valid,
  input  logic             pix_ready
);

  typedef enum logic [1:0] {
    IDLE,
    FRAC,
    INT,
    OUT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [2:0]       imode_q;
  logic [3:0][15:0] ai_q, ii_q;
  logic [3:0][15:0] q_v, a_v, b_v;

`ifdef GOURAUD_FRAC_EN
  logic [3:0][15:0] af_q, nf_q;
  localparam state_t FIRST = FRAC;
`else
  localparam state_t FIRST = INT;
`endif

  assign q_v = {addq_3, addq_2, addq_1, addq_0};

  assign adda_0 = a_v[0];
  assign adda_1 = a_v[1];
  assign adda_2 = a_v[2];
  assign adda_3 = a_v[3];
  assign addb_0 = b_v[0];
  assign addb_1 = b_v[1];
  assign addb_2 = b_v[2];
  assign addb_3 = b_v[3];

  assign pix_0 = ai_q[0];
  assign pix_1 = ai_q[1];
  assign pix_2 = ai_q[2];
  assign pix_3 = ai_q[3];

  assign busy      = (state_q != IDLE);
  assign pix_valid = (state_q == OUT);
  assign done      = done_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    a_v       = '0;
    b_v       = '0;
    daddmode  = 3'b000;
    carry_clk = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            cnt_d   = count;
            state_d = FIRST;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      FRAC: begin
`ifdef GOURAUD_FRAC_EN
        // Carry-in suppressed; carry-out latched for the INT phase
        a_v       = af_q;
        b_v       = nf_q;
        daddmode  = 3'b100;
        carry_clk = 1'b1;
`endif
        state_d = INT;
      end
      INT: begin
        a_v      = ai_q;
        b_v      = ii_q;
        daddmode = imode_q;
        state_d  = OUT;
      end
      OUT: begin
        if (pix_ready) begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = FIRST;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      imode_q <= 3'b000;
      ai_q    <= '0;
      ii_q    <= '0;
`ifdef GOURAUD_FRAC_EN
      af_q    <= '0;
      nf_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      if (state_q == IDLE && ld_we) begin
        unique case (ld_sel)
          3'd1: ai_q[ld_lane] <= ld_data;
          3'd3: ii_q[ld_lane] <= ld_data;
          3'd4: imode_q <= ld_data[2:0];
`ifdef GOURAUD_FRAC_EN
          3'd0: af_q[ld_lane] <= ld_data;
          3'd2: nf_q[ld_lane] <= ld_data;
`endif
          default: ;
        endcase
      end
      if (state_q == INT) ai_q <= q_v;
`ifdef GOURAUD_FRAC_EN
      if (state_q == FRAC) af_q <= q_v;
`endif
    end
  end

endmodule

// File: tb/tb_gouraud_step.sv
// Directed bench for gouraud_step with a behavioural add-array model.
// Expectations follow the GOURAUD_FRAC_EN setting of the build.
module tb_gouraud_step;
  localparam int CNT_W = 16;
`ifdef GOURAUD_FRAC_EN
  localparam int LAT = 3;
  localparam int STEP = 3;
  localparam logic FRAC_ON = 1'b1;
`else
  localparam int LAT = 2;
  localparam int STEP = 2;
  localparam logic FRAC_ON = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic reset, ld_we, start, pix_ready;
  logic [2:0] ld_sel;
  logic [1:0] ld_lane;
  logic [15:0] ld_data;
  logic [CNT_W-1:0] count;
  logic busy, done, carry_clk, pix_valid;
  logic [2:0] daddmode;
  logic [15:0] adda_0, adda_1, adda_2, adda_3;
  logic [15:0] addb_0, addb_1, addb_2, addb_3;
  logic [15:0] addq_0, addq_1, addq_2, addq_3;
  logic [15:0] pix_0, pix_1, pix_2, pix_3;

  gouraud_step #(.CNT_W(CNT_W)) dut (
    .sys_clk(sys_clk), .reset(reset),
    .ld_we(ld_we), .ld_sel(ld_sel), .ld_lane(ld_lane), .ld_data(ld_data),
    .start(start), .count(count), .busy(busy), .done(done),
    .adda_0(adda_0), .adda_1(adda_1), .adda_2(adda_2), .adda_3(adda_3),
    .addb_0(addb_0), .addb_1(addb_1), .addb_2(addb_2), .addb_3(addb_3),
    .daddmode(daddmode), .carry_clk(carry_clk),
    .addq_0(addq_0), .addq_1(addq_1), .addq_2(addq_2), .addq_3(addq_3),
    .pix_0(pix_0), .pix_1(pix_1), .pix_2(pix_2), .pix_3(pix_3),
    .pix_valid(pix_valid), .pix_ready(pix_ready)
  );

  always #5 sys_clk = ~sys_clk;

  // Add-array model: carry latched on carry_clk, applied for modes 1..3
  logic [3:0][15:0] av, bv, qv;
  logic [3:0] cy_q, co_v;
  logic [16:0] s17;
  logic cin_en;
  assign av = {adda_3, adda_2, adda_1, adda_0};
  assign bv = {addb_3, addb_2, addb_1, addb_0};
  assign cin_en = (daddmode == 3'd1) || (daddmode == 3'd2) || (daddmode == 3'd3);
  always_comb begin
    qv = '0;
    co_v = '0;
    s17 = '0;
    for (int l = 0; l < 4; l++) begin
      s17 = {1'b0, av[l]} + {1'b0, bv[l]};
      co_v[l] = s17[16];
      qv[l] = av[l] + bv[l] + {15'd0, cy_q[l] & cin_en};
    end
  end
  assign addq_0 = qv[0];
  assign addq_1 = qv[1];
  assign addq_2 = qv[2];
  assign addq_3 = qv[3];
  always @(posedge sys_clk) begin
    if (reset) cy_q <= '0;
    else if (carry_clk) cy_q <= co_v;
  end

  logic cc_seen = 1'b0;
  always @(negedge sys_clk) if (carry_clk) cc_seen <= 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [1:0]       lane;
    logic [15:0]      ai;
    logic [15:0]      ii;
    logic [15:0]      af;
    logic [15:0]      nf;
    logic [2:0]       im;
    logic [3:0]       n;
    logic [2:0][15:0] e;
  } vec_t;

  vec_t vecs[3];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [15:0] pix_of(input int l);
    case (l % 4)
      0: return pix_0;
      1: return pix_1;
      2: return pix_2;
      default: return pix_3;
    endcase
  endfunction

  function automatic logic [15:0] a_of(input int l);
    return av[l % 4];
  endfunction

  function automatic logic [15:0] b_of(input int l);
    return bv[l % 4];
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    ld_we = 1'b0;
    start = 1'b0;
    pix_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic ld(input logic [2:0] s, input logic [1:0] l,
                    input logic [15:0] d);
    ld_we = 1'b1;
    ld_sel = s;
    ld_lane = l;
    ld_data = d;
    tick();
    ld_we = 1'b0;
  endtask

  task automatic setup(input vec_t v);
    do_reset();
    ld(3'd1, v.lane, v.ai);
    ld(3'd3, v.lane, v.ii);
    ld(3'd0, v.lane, v.af);
    ld(3'd2, v.lane, v.nf);
    ld(3'd4, 2'd0, {13'd0, v.im});
  endtask

  task automatic run(input vec_t v, input int stall, input logic poke);
    int cyc;
    pix_ready = (stall == 0);
    start = 1'b1;
    count = CNT_W'(v.n);
    tick();
    start = 1'b0;
    cyc = 1;
    for (int k = 0; k < int'(v.n); k++) begin
      while (!pix_valid && cyc < 40) begin
        // a write while busy must leave the result untouched
        ld_we = poke && (cyc == 1);
        ld_sel = 3'd3;
        ld_lane = v.lane;
        ld_data = 16'h0F00;
        if (k == 0 && cyc == LAT - 1) begin
          chk("int_op_a", {16'd0, a_of(v.lane)}, {16'd0, v.ai});
          chk("int_op_b", {16'd0, b_of(v.lane)}, {16'd0, v.ii});
          chk("int_mode", {29'd0, daddmode}, {29'd0, v.im});
        end
        tick();
        cyc++;
      end
      ld_we = 1'b0;
      chk("pix_valid", {31'd0, pix_valid}, 32'd1);
      chk("pix_val", {16'd0, pix_of(v.lane)}, {16'd0, v.e[k]});
      chk("pix_other", {16'd0, pix_of(v.lane + 1)}, 32'd0);
      chk("pix_cyc", cyc, LAT + k * STEP + ((k > 0) ? stall : 0));
      if (k == 0 && stall > 0) begin
        repeat (stall) begin
          tick();
          cyc++;
          chk("hold_valid", {31'd0, pix_valid}, 32'd1);
          chk("hold_pix", {16'd0, pix_of(v.lane)}, {16'd0, v.e[0]});
          chk("hold_a", {16'd0, a_of(v.lane)}, 32'd0);
          chk("hold_mode", {29'd0, daddmode}, 32'd0);
        end
        pix_ready = 1'b1;
      end
      tick();
      cyc++;
    end
    chk("done", {31'd0, done}, 32'd1);
    chk("busy_end", {31'd0, busy}, 32'd0);
    tick();
    chk("done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    vec_t z;
`ifdef GOURAUD_FRAC_EN
    vecs[0] = '{2'd0, 16'h0010, 16'h0001, 16'hC000, 16'h8000, 3'd1, 4'd2,
                {16'h0000, 16'h0013, 16'h0012}};
    vecs[1] = '{2'd1, 16'h0010, 16'h0001, 16'hC000, 16'h8000, 3'd0, 4'd2,
                {16'h0000, 16'h0012, 16'h0011}};
    vecs[2] = '{2'd3, 16'h1234, 16'h0100, 16'h0000, 16'h0000, 3'd2, 4'd1,
                {16'h0000, 16'h0000, 16'h1334}};
`else
    vecs[0] = '{2'd0, 16'h0100, 16'h0002, 16'hC000, 16'h8000, 3'd0, 4'd3,
                {16'h0106, 16'h0104, 16'h0102}};
    vecs[1] = '{2'd2, 16'hFFFF, 16'h0001, 16'hC000, 16'hC000, 3'd1, 4'd2,
                {16'h0000, 16'h0001, 16'h0000}};
    vecs[2] = '{2'd3, 16'h1234, 16'h0100, 16'h0000, 16'h0000, 3'd2, 4'd1,
                {16'h0000, 16'h0000, 16'h1334}};
`endif
    ld_sel = '0;
    ld_lane = '0;
    ld_data = '0;
    count = '0;
    do_reset();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_valid", {31'd0, pix_valid}, 32'd0);
    chk("rst_cclk", {31'd0, carry_clk}, 32'd0);
    chk("rst_mode", {29'd0, daddmode}, 32'd0);
    chk("rst_a_b", {adda_0, addb_3}, 32'd0);
    chk("rst_pix", {pix_0 | pix_1, pix_2 | pix_3}, 32'd0);

    for (int i = 0; i < 3; i++) begin
      setup(vecs[i]);
      run(vecs[i], 0, 1'b0);
    end

    // first pixel stalled 4 cycles
    setup(vecs[0]);
    run(vecs[0], 4, 1'b0);

    // loads while busy are dropped
    setup(vecs[0]);
    run(vecs[0], 0, 1'b1);

    // zero-length run
    do_reset();
    start = 1'b1;
    count = '0;
    chk("cnt0_busy_pre", {31'd0, busy}, 32'd0);
    tick();
    start = 1'b0;
    chk("cnt0_done", {31'd0, done}, 32'd1);
    chk("cnt0_busy", {31'd0, busy}, 32'd0);
    chk("cnt0_valid", {31'd0, pix_valid}, 32'd0);
    tick();
    chk("cnt0_done_clr", {31'd0, done}, 32'd0);
    chk("cnt0_valid2", {31'd0, pix_valid}, 32'd0);

    // reset during INT of the first step
    setup(vecs[0]);
    start = 1'b1;
    count = CNT_W'(2);
    tick();
    start = 1'b0;
    repeat (LAT - 2) tick();
    chk("mid_int_mode", {29'd0, daddmode}, {29'd0, vecs[0].im});
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_valid", {31'd0, pix_valid}, 32'd0);
    chk("mrst_pix", {pix_0 | pix_1, pix_2 | pix_3}, 32'd0);
    tick();
    chk("mrst_done2", {31'd0, done}, 32'd0);
    z = '0;
    z.n = 4'd1;
    run(z, 0, 1'b0);

    chk("carry_clk_seen", {31'd0, cc_seen}, {31'd0, FRAC_ON});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
